// File: rtl/prop_pkg.sv
// Shared types and constants for the propagation sequencer.
//   state_e        : sequencer FSM states
//   LFSR_TAPS      : Galois feedback mask for x^8+x^6+x^5+x^4+1
//   LFSR_ZERO_FIX  : substitute seed used when an all-zero seed is requested
//   lfsr_next()    : one Galois right-shift step
package prop_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FWD  = 3'd1,
    LOSS = 3'd2,
    BWD  = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam logic [7:0] LFSR_TAPS     = 8'hB8;
  localparam logic [7:0] LFSR_ZERO_FIX = 8'hFF;

  // Right-shifting Galois step: when the bit leaving at the bottom is 1,
  // the tap mask is folded back in. A non-zero state never maps to zero.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit maximal-length Galois LFSR (period 255), advancing every cycle
// that is not a reset cycle.
//   clk_in  : clock
//   rst_in  : synchronous active-high reset, loads the seed
//   rnd_out : current LFSR state
module lfsr8
  import prop_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk_in,
  input  logic       rst_in,
  output logic [7:0] rnd_out
);

  // An all-zero state would lock the register, so such a seed is remapped.
  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? LFSR_ZERO_FIX : SEED;

  logic [7:0] rnd_q, rnd_d;

  always_comb begin
    rnd_d = lfsr_next(rnd_q);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) rnd_q <= SEED_EFF;
    else        rnd_q <= rnd_d;
  end

  assign rnd_out = rnd_q;

endmodule

// File: rtl/prop_sequencer.sv
// Propagation sequencer: per sample, pulses the forward strobes layer
// 0..N-1, a loss-latch strobe, then (training only) the backward strobes
// layer N-1..0, then a one-cycle done. Each step lasts GAP+1 cycles with
// the strobe on the first cycle only. Also broadcasts the LFSR stream.
//   clk_in, rst_in    : clock, synchronous active-high reset
//   sample_valid_in   : sample available (handshake with sample_ready_out)
//   train_en_in       : captured at handshake, enables the backward pass
//   sample_ready_out  : high in IDLE only
//   fd_prop_out       : one-hot forward strobe per layer
//   loss_latch_out    : loss capture strobe
//   bk_prop_out       : one-hot backward strobe per layer
//   done_out          : one-cycle completion pulse
//   busy_out          : high outside IDLE
//   rnd_out           : shared random byte
//   sample_count_out  : completed training samples (wrapping)
module prop_sequencer
  import prop_pkg::*;
#(
  parameter int         NUM_LAYERS = 3,
  parameter int         GAP        = 0,
  parameter logic [7:0] SEED       = 8'hA5
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  sample_valid_in,
  input  logic                  train_en_in,
  output logic                  sample_ready_out,
  output logic [NUM_LAYERS-1:0] fd_prop_out,
  output logic                  loss_latch_out,
  output logic [NUM_LAYERS-1:0] bk_prop_out,
  output logic                  done_out,
  output logic                  busy_out,
  output logic [7:0]            rnd_out,
  output logic [15:0]           sample_count_out
);

  localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(GAP);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic                    train_q, train_d;
  logic [NUM_LAYERS-1:0]   fd_q, fd_d;
  logic [NUM_LAYERS-1:0]   bk_q, bk_d;
  logic                    loss_q, loss_d;
  logic                    done_q, done_d;
  logic [15:0]             count_q, count_d;
  logic                    step_end;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    train_d  = train_q;
    count_d  = count_q;
    step_end = (gap_q == GAP_MAX);

    case (state_q)
      IDLE: begin
        if (sample_valid_in) begin
          state_d = FWD;
          idx_d   = '0;
          gap_d   = '0;
          train_d = train_en_in;
        end
      end
      FWD: begin
        if (step_end) begin
          gap_d = '0;
          if (idx_q == LAST_IDX) state_d = LOSS;
          else                   idx_d   = idx_q + IDX_W'(1);
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      LOSS: begin
        if (step_end) begin
          gap_d = '0;
          if (train_q) begin
            state_d = BWD;
            idx_d   = LAST_IDX;
          end else begin
            state_d = DONE;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      BWD: begin
        if (step_end) begin
          gap_d = '0;
          if (idx_q == '0) state_d = DONE;
          else             idx_d   = idx_q - IDX_W'(1);
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
        gap_d   = '0;
      end
      default: state_d = IDLE;
    endcase

    // Strobes are registered from the next-state view so that each one
    // lands on the first cycle of its step. gap_d returns to 0 only when
    // a new step starts, which makes it the step-start marker.
    fd_d   = (state_d == FWD && gap_d == '0) ? (NUM_LAYERS'(1) << idx_d) : '0;
    bk_d   = (state_d == BWD && gap_d == '0) ? (NUM_LAYERS'(1) << idx_d) : '0;
    loss_d = (state_d == LOSS && gap_d == '0);
    done_d = (state_d == DONE);

    // DONE is only entered from LOSS/BWD and lasts one cycle, so this
    // fires once per completed training sample, visible during DONE.
    if (state_d == DONE && train_q) count_d = count_q + 16'd1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      train_q <= 1'b0;
      fd_q    <= '0;
      bk_q    <= '0;
      loss_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      train_q <= train_d;
      fd_q    <= fd_d;
      bk_q    <= bk_d;
      loss_q  <= loss_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  lfsr8 #(.SEED(SEED)) u_lfsr (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .rnd_out (rnd_out)
  );

  assign sample_ready_out = (state_q == IDLE);
  assign busy_out         = (state_q != IDLE);
  assign fd_prop_out      = fd_q;
  assign bk_prop_out      = bk_q;
  assign loss_latch_out   = loss_q;
  assign done_out         = done_q;
  assign sample_count_out = count_q;

endmodule

// File: tb/tb_prop_sequencer.sv
module tb_prop_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT A: N=3, GAP=0
  logic       valid_a, train_a, ready_a, loss_a, done_a, busy_a;
  logic [2:0] fd_a, bk_a;
  logic [7:0] rnd_a;
  logic [15:0] count_a;

  // DUT B: N=2, GAP=2
  logic       valid_b, train_b, ready_b, loss_b, done_b, busy_b;
  logic [1:0] fd_b, bk_b;
  logic [7:0] rnd_b;
  logic [15:0] count_b;

  prop_sequencer #(.NUM_LAYERS(3), .GAP(0), .SEED(8'hA5)) dut_a (
    .clk_in(clk), .rst_in(rst), .sample_valid_in(valid_a), .train_en_in(train_a),
    .sample_ready_out(ready_a), .fd_prop_out(fd_a), .loss_latch_out(loss_a),
    .bk_prop_out(bk_a), .done_out(done_a), .busy_out(busy_a), .rnd_out(rnd_a),
    .sample_count_out(count_a));

  prop_sequencer #(.NUM_LAYERS(2), .GAP(2), .SEED(8'hA5)) dut_b (
    .clk_in(clk), .rst_in(rst), .sample_valid_in(valid_b), .train_en_in(train_b),
    .sample_ready_out(ready_b), .fd_prop_out(fd_b), .loss_latch_out(loss_b),
    .bk_prop_out(bk_b), .done_out(done_b), .busy_out(busy_b), .rnd_out(rnd_b),
    .sample_count_out(count_b));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_next(input logic [7:0] v);
    logic [7:0] r;
    r = {1'b0, v[7:1]};
    if (v[0]) r = r ^ 8'b1011_1000; // x^8+x^6+x^5+x^4+1
    return r;
  endfunction

  // {fd[2:0], loss, bk[2:0], done} for DUT A, indexed by cycle offset from T
  logic [7:0] exp_inf [1:5];
  logic [7:0] exp_tr  [1:8];
  // {fd[1:0], loss, bk[1:0], done} for DUT B
  logic [5:0] exp_b   [1:16];

  logic [7:0] obs_rnd [0:509];
  logic [7:0] m;
  int bad_model, zeros, first_rep, per_err;
  int hs, done_n, bk_n, base_cnt;
  int hs_cyc [0:3];

  initial begin
    exp_inf = '{8'b001_0_000_0, 8'b010_0_000_0, 8'b100_0_000_0,
                8'b000_1_000_0, 8'b000_0_000_1};
    exp_tr  = '{8'b001_0_000_0, 8'b010_0_000_0, 8'b100_0_000_0, 8'b000_1_000_0,
                8'b000_0_100_0, 8'b000_0_010_0, 8'b000_0_001_0, 8'b000_0_000_1};
    for (int i = 1; i <= 16; i++) exp_b[i] = 6'b0;
    exp_b[1]  = 6'b01_0_00_0;
    exp_b[4]  = 6'b10_0_00_0;
    exp_b[7]  = 6'b00_1_00_0;
    exp_b[10] = 6'b00_0_10_0;
    exp_b[13] = 6'b00_0_01_0;
    exp_b[16] = 6'b00_0_00_1;

    rst = 1'b1; valid_a = 1'b0; train_a = 1'b0; valid_b = 1'b0; train_b = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_ready",  ready_a, 1);
    chk("rst_busy",   busy_a, 0);
    chk("rst_strobe", {fd_a, loss_a, bk_a, done_a}, 0);
    chk("rst_rnd",    rnd_a, 8'hA5);
    chk("rst_count",  count_a, 0);
    chk("rst_b_ready", ready_b, 1);

    // LFSR: 510 samples starting at the reset value
    obs_rnd[0] = rnd_a;
    m = 8'hA5;
    bad_model = 0; zeros = 0;
    rst = 1'b0;
    for (int i = 1; i < 510; i++) begin
      @(negedge clk);
      m = model_next(m);
      obs_rnd[i] = rnd_a;
      if (rnd_a !== m) bad_model++;
      if (rnd_a == 8'h00) zeros++;
    end
    first_rep = 0;
    for (int i = 1; i < 510; i++)
      if (first_rep == 0 && obs_rnd[i] == obs_rnd[0]) first_rep = i;
    per_err = 0;
    for (int i = 0; i < 255; i++)
      if (obs_rnd[i + 255] !== obs_rnd[i]) per_err++;
    chk("lfsr_first",        obs_rnd[0], 8'hA5);
    chk("lfsr_model_errs",   bad_model, 0);
    chk("lfsr_zero_seen",    zeros, 0);
    chk("lfsr_first_repeat", first_rep, 255);
    chk("lfsr_period_errs",  per_err, 0);

    // Inference on A: done at T+5, count unchanged
    valid_a = 1'b1; train_a = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) begin
        valid_a = 1'b0;
        chk("inf_busy",  busy_a, 1);
        chk("inf_ready", ready_a, 0);
      end
      chk($sformatf("inf_c%0d", i), {fd_a, loss_a, bk_a, done_a}, exp_inf[i]);
    end
    @(negedge clk);
    chk("inf_idle_ready", ready_a, 1);
    chk("inf_count",      count_a, 0);

    // Training on A: done at T+8, count 1
    valid_a = 1'b1; train_a = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin valid_a = 1'b0; train_a = 1'b0; end
      chk($sformatf("tr_c%0d", i), {fd_a, loss_a, bk_a, done_a}, exp_tr[i]);
    end
    chk("tr_count_in_done", count_a, 1);
    @(negedge clk);
    chk("tr_idle_ready", ready_a, 1);
    chk("tr_count",      count_a, 1);

    // Training on B (N=2, GAP=2): strobes every 3 cycles, done at T+16
    valid_b = 1'b1; train_b = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1) begin valid_b = 1'b0; train_b = 1'b0; end
      chk($sformatf("gap_c%0d", i), {fd_b, loss_b, bk_b, done_b}, exp_b[i]);
    end
    @(negedge clk);
    chk("gap_count", count_b, 1);
    chk("gap_ready", ready_b, 1);

    // Reset during BWD on A
    valid_a = 1'b1; train_a = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) begin valid_a = 1'b0; train_a = 1'b0; end
    end
    chk("mid_bwd_strobe", {fd_a, loss_a, bk_a, done_a}, 8'b000_0_010_0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_strobe", {fd_a, loss_a, bk_a, done_a}, 0);
    chk("mid_rst_ready",  ready_a, 1);
    chk("mid_rst_busy",   busy_a, 0);
    chk("mid_rst_rnd",    rnd_a, 8'hA5);
    chk("mid_rst_count",  count_a, 0);
    rst = 1'b0;
    valid_a = 1'b1; train_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0; train_a = 1'b0;
    chk("restart_fd0", {fd_a, loss_a, bk_a, done_a}, 8'b001_0_000_0);
    repeat (7) @(negedge clk);
    chk("restart_done",  done_a, 1);
    chk("restart_count", count_a, 1);
    @(negedge clk);
    chk("restart_idle", ready_a, 1);

    // Valid held high for four samples; train toggled while busy
    base_cnt = count_a;
    hs = 0; done_n = 0; bk_n = 0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      done_n += int'(done_a);
      bk_n   += $countones(bk_a);
      valid_a = (hs < 4);
      train_a = ready_a ? 1'b1 : ~train_a;
      if (ready_a && valid_a) begin
        hs_cyc[hs] = c;
        hs++;
      end
    end
    valid_a = 1'b0;
    chk("hold_handshakes", hs, 4);
    chk("hold_gap_1", hs_cyc[1] - hs_cyc[0], 9);
    chk("hold_gap_2", hs_cyc[2] - hs_cyc[1], 9);
    chk("hold_gap_3", hs_cyc[3] - hs_cyc[2], 9);
    chk("hold_done_pulses", done_n, 4);
    chk("hold_bk_pulses",   bk_n, 12);
    chk("hold_count",       count_a, base_cnt + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prop_sequencer.md
Name: prop_sequencer

Overview:
- Control stage directly upstream of the learning units: generates the per-layer forward and backward propagation strobes and the shared 8-bit random stream.
- Feeds the units' fd_prop, bk_prop and rnd_in inputs, and the loss/error register via loss_latch_out.
- Accepts one sample per valid/ready handshake.
- Sequences forward pulses layer 0..N-1, then a loss latch, then (training only) backward pulses layer N-1..0, then signals done.

Parameters:
- NUM_LAYERS, 3, number of unit layers sequenced (>=1).
- GAP, 0, idle cycles inserted after every strobe (settling for deep combinational layers).
- SEED, 8'hA5, LFSR reset value; 8'h00 is illegal and is replaced by 8'hFF.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- sample_valid_in  input  1  loader presents a sample (fin of layer 0 stable)
- train_en_in  input  1  sampled at handshake; 1 = run backward pass
- sample_ready_out  output  1  high only in IDLE
- fd_prop_out  output  NUM_LAYERS  one-hot forward strobe, bit k drives layer k
- loss_latch_out  output  1  one-cycle strobe capturing output error into last layer's bin
- bk_prop_out  output  NUM_LAYERS  one-hot backward strobe
- done_out  output  1  one-cycle pulse when the sample completes
- busy_out  output  1  high in every state except IDLE
- rnd_out  output  8  LFSR value broadcast to all accumulators
- sample_count_out  output  16  completed training samples, wraps at 16'hFFFF->0

Behaviour:
- Reset (synchronous, active-high, dominant over all other inputs, including mid-sequence):
  - state=IDLE, all strobes 0, done_out=0, busy_out=0, sample_ready_out=1.
  - rnd_out=SEED (or 8'hFF if SEED==0), sample_count_out=0, layer index=0, gap counter=0.
- States: IDLE, FWD, LOSS, BWD, DONE.
- Each step (one FWD layer, LOSS, or one BWD layer) occupies GAP+1 cycles. The strobe is high only on the first cycle of the step; the remaining GAP cycles are all-zero.
- IDLE:
  - Handshake when sample_valid_in && sample_ready_out at cycle T.
  - Latch train_en_in; layer index=0; go to FWD.
  - First strobe, fd_prop_out[0], is at T+1.
- FWD:
  - Pulse fd_prop_out[idx], then wait GAP cycles.
  - If idx==NUM_LAYERS-1, go to LOSS; else idx+1.
- LOSS:
  - Pulse loss_latch_out, then wait GAP cycles.
  - If latched train=1, go to BWD with idx=NUM_LAYERS-1; else go to DONE.
- BWD:
  - Pulse bk_prop_out[idx], then wait GAP cycles.
  - If idx==0, go to DONE; else idx-1.
- DONE:
  - One cycle; done_out=1.
  - sample_count_out increments in this cycle only if train was latched.
  - Next state is IDLE.
  - sample_ready_out is 0 in DONE, so the earliest next handshake is the cycle after DONE.
- Latency, N=3, GAP=0: training done at T+8, inference done at T+5. General case: done at T+1+(2N+1)(GAP+1) for training and T+1+(N+1)(GAP+1) for inference.
- At most one strobe bit across fd_prop_out, bk_prop_out and loss_latch_out is high in any cycle. Strobes are registered outputs.
- sample_valid_in and train_en_in are ignored outside IDLE. A sample held valid through a whole sequence is accepted exactly once per sequence.
- LFSR:
  - 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1, maximal period 255.
  - Advances every non-reset cycle, independent of state.
  - Never reaches 0.
- Width rules:
  - Layer index is $clog2(NUM_LAYERS) bits, minimum 1.
  - Gap counter is $clog2(GAP+1) bits, minimum 1.
  - NUM_LAYERS==1: FWD and BWD each run one step.

Decomposition:
- Shared package prop_pkg holds:
  - the state enum (IDLE, FWD, LOSS, BWD, DONE);
  - LFSR_TAPS = 8'hB8;
  - LFSR_ZERO_FIX = 8'hFF.
- One sub-module, lfsr8, with clk_in, rst_in, seed parameter and 8-bit output. The same module can later be reused to seed per-unit oscillators.

Test Plan:
- Reset, then N=3, GAP=0, train_en_in=1, valid at T: fd_prop_out=001,010,100 at T+1..T+3; loss at T+4; bk_prop_out=100,010,001 at T+5..T+7; done at T+8; sample_count_out=1.
- Same with train_en_in=0: loss at T+4, no bk strobes, done at T+5, sample_count_out stays 0.
- GAP=2, N=2, training: strobes at T+1, T+4, T+7, T+10, T+13; done at T+16; all intermediate cycles all-zero.
- Assert rst_in during BWD (cycle T+6): next cycle all strobes 0, ready=1, rnd_out=8'hA5, count=0; a new handshake restarts at fd_prop_out[0].
- Hold valid high continuously for 4 samples: exactly 4 handshakes, each 9 cycles apart (N=3, GAP=0); train_en_in toggled mid-sequence has no effect.
- Run 510 cycles from reset: rnd_out never 0 and repeats with period exactly 255; first value after reset is 8'hA5.
